bmem_arbiter: RTL and testbench

Arbiter and line adapter between the instruction cache, the data cache and the single banked-memory port of `cpu`. It grants one cache at a time with round-robin priority. Each 256-bit cacheline transfer becomes a 4-beat, 64-bit burst on the `bmem_*` interface. It drives `bmem_addr/read/write/wdata` and consumes `bmem_ready/raddr/rdata/rvalid` directly at the CPU boundary.

---
 rtl/bmem_pkg.sv | 40 ++++
 rtl/bmem_if.sv | 28 ++
 rtl/bmem_line_buf.sv | 57 +++++
 rtl/bmem_arbiter.sv | 157 +++++++++++++++
 tb/tb_bmem_arbiter.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bmem_pkg.sv
// Shared types and constants for the banked-memory arbiter.
//   arb_state_t      : arbiter FSM states
//   grant_t          : which cache owns the memory port
//   BEATS            : beats per cacheline burst
//   CNT_W            : width of the beat counter
//   LINE_OFFSET_BITS : low address bits cleared to form a line address
//   rr_pick()        : round-robin winner selection
package bmem_pkg;

    localparam int BEATS            = 4;
    localparam int CNT_W            = 2;
    localparam int LINE_OFFSET_BITS = 5;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_WAIT  = 3'd2,
        WR_BURST = 3'd3,
        DONE     = 3'd4
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    // A lone request wins outright; on a tie the cache not served last wins.
    function automatic grant_t rr_pick(input logic i_req, input logic d_req, input grant_t last);
        grant_t pick;
        if (i_req && d_req) begin
            pick = (last == GRANT_I) ? GRANT_D : GRANT_I;
        end else if (d_req) begin
            pick = GRANT_D;
        end else begin
            pick = GRANT_I;
        end
        return pick;
    endfunction

endpackage

// File: rtl/bmem_if.sv
// Banked-memory port bundle.
//   master : driven by the arbiter (addr/read/write/wdata out; ready/raddr/rdata/rvalid in)
//   slave  : the memory side of the same bundle
interface bmem_if #(
    parameter int ADDR_W = 32,
    parameter int BEAT_W = 64
) ();

    logic [ADDR_W-1:0] bmem_addr;
    logic              bmem_read;
    logic              bmem_write;
    logic [BEAT_W-1:0] bmem_wdata;
    logic              bmem_ready;
    logic [ADDR_W-1:0] bmem_raddr;
    logic [BEAT_W-1:0] bmem_rdata;
    logic              bmem_rvalid;

    modport master (
        output bmem_addr, bmem_read, bmem_write, bmem_wdata,
        input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
    );

    modport slave (
        input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
        output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
    );

endinterface

// File: rtl/bmem_line_buf.sv
// Cacheline buffer: line register plus beat counter.
//   load      : capture load_data (write line) and restart the counter
//   clear     : restart the counter, line kept
//   shift_en  : one beat transferred; in read mode beat_in lands in slot cnt
//   wr_mode   : suppresses beat insertion while a write line is being sent
//   line      : full line register
//   beat_out  : slot cnt of the line (current write beat)
//   last_beat : counter is on the final slot
module bmem_line_buf
    import bmem_pkg::*;
#(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic              shift_en,
    input  logic              wr_mode,
    input  logic [LINE_W-1:0] load_data,
    input  logic [BEAT_W-1:0] beat_in,
    output logic [LINE_W-1:0] line,
    output logic [BEAT_W-1:0] beat_out,
    output logic              last_beat
);

    logic [LINE_W-1:0] line_r;
    logic [CNT_W-1:0]  cnt_r;

    // Line storage and beat counter
    always_ff @(posedge clk) begin
        if (rst) begin
            line_r <= '0;
            cnt_r  <= '0;
        end else if (load) begin
            line_r <= load_data;
            cnt_r  <= '0;
        end else if (clear) begin
            cnt_r  <= '0;
        end else if (shift_en) begin
            if (!wr_mode) begin
                line_r[cnt_r*BEAT_W +: BEAT_W] <= beat_in;
            end
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Current write beat
    always_comb begin
        beat_out = line_r[cnt_r*BEAT_W +: BEAT_W];
    end

    assign line      = line_r;
    assign last_beat = (cnt_r == CNT_W'(BEATS - 1));

endmodule

// File: rtl/bmem_arbiter.sv
// Round-robin arbiter between icache and dcache for the single banked-memory
// port; each 256-bit line moves as a 4-beat, 64-bit burst.
//   clk, rst               : clock, synchronous active-high reset
//   i_addr/i_read          : icache line read request (level, held until i_resp)
//   i_rdata/i_resp         : icache line and one-cycle completion pulse
//   d_addr/d_read/d_write  : dcache request (level, held until d_resp)
//   d_wdata                : dcache write line
//   d_rdata/d_resp         : dcache line and one-cycle completion pulse
//   bmem                   : banked-memory port (master side)
module bmem_arbiter
    import bmem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_read,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    bmem_if.master            bmem
);

    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << LINE_OFFSET_BITS) - 1);

    arb_state_t        state_r;
    arb_state_t        next_state_s;
    grant_t            grant_r;
    grant_t            last_grant_r;
    grant_t            pick_s;
    logic              wr_r;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] addr_sel_s;
    logic              latch_s;
    logic              load_s;
    logic              clear_s;
    logic              shift_s;
    logic              beat_hit_s;
    logic [LINE_W-1:0] line_s;
    logic [BEAT_W-1:0] beat_out_s;
    logic              last_beat_s;

    // Next state and line-buffer controls
    always_comb begin
        next_state_s = state_r;
        pick_s       = rr_pick(i_read, d_read || d_write, last_grant_r);
        addr_sel_s   = (pick_s == GRANT_D) ? d_addr : i_addr;
        latch_s      = 1'b0;
        load_s       = 1'b0;
        clear_s      = 1'b0;
        shift_s      = 1'b0;
        // Only beats tagged with the line in flight count
        beat_hit_s   = bmem.bmem_rvalid && (bmem.bmem_raddr == addr_r);
        case (state_r)
            IDLE: begin
                if (i_read || d_read || d_write) begin
                    latch_s = 1'b1;
                    if ((pick_s == GRANT_D) && d_write) begin
                        load_s       = 1'b1;
                        next_state_s = WR_BURST;
                    end else begin
                        next_state_s = RD_ISSUE;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            RD_ISSUE: begin
                if (bmem.bmem_ready) begin
                    next_state_s = RD_WAIT;
                end else begin
                    next_state_s = RD_ISSUE;
                end
            end
            RD_WAIT: begin
                if (beat_hit_s) begin
                    shift_s      = 1'b1;
                    next_state_s = last_beat_s ? DONE : RD_WAIT;
                end else begin
                    next_state_s = RD_WAIT;
                end
            end
            WR_BURST: begin
                if (bmem.bmem_ready) begin
                    shift_s      = 1'b1;
                    next_state_s = last_beat_s ? DONE : WR_BURST;
                end else begin
                    next_state_s = WR_BURST;
                end
            end
            DONE: begin
                clear_s      = 1'b1;
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State, grant and latched line address
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            grant_r      <= GRANT_I;
            last_grant_r <= GRANT_I;
            wr_r         <= 1'b0;
            addr_r       <= '0;
        end else begin
            state_r <= next_state_s;
            if (latch_s) begin
                grant_r <= pick_s;
                wr_r    <= (pick_s == GRANT_D) && d_write;
                addr_r  <= addr_sel_s & LINE_MASK;
            end
            if (state_r == DONE) begin
                last_grant_r <= grant_r;
            end
        end
    end

    bmem_line_buf #(
        .LINE_W (LINE_W),
        .BEAT_W (BEAT_W)
    ) u_line_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (load_s),
        .clear     (clear_s),
        .shift_en  (shift_s),
        .wr_mode   (wr_r),
        .load_data (d_wdata),
        .beat_in   (bmem.bmem_rdata),
        .line      (line_s),
        .beat_out  (beat_out_s),
        .last_beat (last_beat_s)
    );

    // Outputs decode registered state only; no cache input reaches bmem_* combinationally
    assign bmem.bmem_read  = (state_r == RD_ISSUE);
    assign bmem.bmem_write = (state_r == WR_BURST);
    assign bmem.bmem_addr  = ((state_r == RD_ISSUE) || (state_r == WR_BURST)) ? addr_r : '0;
    assign bmem.bmem_wdata = (state_r == WR_BURST) ? beat_out_s : '0;
    assign i_resp          = (state_r == DONE) && (grant_r == GRANT_I);
    assign d_resp          = (state_r == DONE) && (grant_r == GRANT_D);
    assign i_rdata         = line_s;
    assign d_rdata         = line_s;

endmodule

// File: tb/tb_bmem_arbiter.sv
// Self-checking bench for bmem_arbiter: directed scenarios plus randomized
// mixed traffic checked against a round-robin / line-assembly reference model.
module tb_bmem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  i_addr, d_addr;
    logic         i_read, d_read, d_write;
    logic [255:0] d_wdata, i_rdata, d_rdata;
    logic         i_resp, d_resp;

    bmem_if #(.ADDR_W(32), .BEAT_W(64)) bus ();

    bmem_arbiter #(.ADDR_W(32), .LINE_W(256), .BEAT_W(64)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_addr  (i_addr),
        .i_read  (i_read),
        .i_rdata (i_rdata),
        .i_resp  (i_resp),
        .d_addr  (d_addr),
        .d_read  (d_read),
        .d_write (d_write),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .d_resp  (d_resp),
        .bmem    (bus)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model state: 1 when the dcache was the last cache served
    bit          model_last_d;
    bit          dual_resp;
    bit          timeout;
    logic [31:0] issue_addr;
    int          resp_cyc, first_wr_cyc;
    logic [63:0] wr_trace[$];
    logic [31:0] waddr_trace[$];

    always @(negedge clk) if (i_resp === 1'b1 && d_resp === 1'b1) dual_resp = 1'b1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic rand_line(output logic [255:0] l);
        for (int k = 0; k < 8; k++) l[32*k +: 32] = $urandom;
    endtask

    // Memory responder for one read: accept the command (random ready delay), then
    // return the four beats with random gaps, optionally filled with wrongly tagged beats.
    // Returns at the cycle after the 4th beat.
    task automatic serve_read(input logic [31:0] tag, input logic [255:0] ln,
                              input bit strays, input logic [31:0] stray_tag);
        int n = 0;
        timeout = 1'b0;
        while (bus.bmem_read !== 1'b1 && n < 30) begin tick(); n++; end
        if (n >= 30) begin timeout = 1'b1; return; end
        issue_addr = bus.bmem_addr;
        bus.bmem_ready = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
        bus.bmem_ready = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            repeat (strays ? $urandom_range(1, 2) : $urandom_range(0, 2)) begin
                bus.bmem_rvalid = strays;
                bus.bmem_raddr  = stray_tag;
                bus.bmem_rdata  = {$urandom, $urandom};
                tick();
            end
            bus.bmem_rvalid = 1'b1;
            bus.bmem_raddr  = tag;
            bus.bmem_rdata  = ln[64*k +: 64];
            tick();
        end
        bus.bmem_rvalid = 1'b0;
    endtask

    // Memory responder for one write: called on the cycle the request is presented
    // (cycle 0); stalls beat stall_beat for stall_len cycles; records every write cycle.
    task automatic serve_write(input int stall_beat, input int stall_len);
        int cyc = 0;
        int acc = 0;
        int st  = stall_len;
        wr_trace.delete();
        waddr_trace.delete();
        resp_cyc = -1;
        first_wr_cyc = -1;
        while (cyc < 40) begin
            tick();
            cyc++;
            if (d_resp === 1'b1) begin resp_cyc = cyc; break; end
            if (bus.bmem_write === 1'b1) begin
                if (first_wr_cyc < 0) first_wr_cyc = cyc;
                wr_trace.push_back(bus.bmem_wdata);
                waddr_trace.push_back(bus.bmem_addr);
                if (acc == stall_beat && st > 0) begin
                    bus.bmem_ready = 1'b0;
                    st--;
                end else begin
                    bus.bmem_ready = 1'b1;
                    acc++;
                end
            end else begin
                bus.bmem_ready = 1'b1;
            end
        end
        timeout = (resp_cyc < 0);
        bus.bmem_ready = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_last_d = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_read = 1'b1; d_write = 1'b1; d_wdata = {8{$urandom}};
        bus.bmem_rvalid = 1'b1; bus.bmem_raddr = 32'h0;
        repeat (2) tick();
        total_cnt++;
        if ({bus.bmem_read, bus.bmem_write, bus.bmem_addr, bus.bmem_wdata} !== 98'b0)
            $display("FAIL reset_bmem: got rd=%b wr=%b addr=%h wdata=%h want all 0",
                     bus.bmem_read, bus.bmem_write, bus.bmem_addr, bus.bmem_wdata);
        else pass_cnt++;
        total_cnt++;
        if ({i_resp, d_resp} !== 2'b00) $display("FAIL reset_resp: got %b want 00", {i_resp, d_resp});
        else pass_cnt++;
        total_cnt++;
        if ({i_rdata, d_rdata} !== 512'b0) $display("FAIL reset_rdata: got %h want 0", i_rdata);
        else pass_cnt++;
        i_read = 1'b0; d_write = 1'b0; bus.bmem_rvalid = 1'b0;
        rst = 1'b0;
        model_last_d = 1'b0;
        tick();
        total_cnt++;
        if (bus.bmem_read !== 1'b0) $display("FAIL idle_after_reset: bmem_read got %b want 0", bus.bmem_read);
        else pass_cnt++;
    endtask

    task automatic test_icache_read();
        logic [255:0] ln = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        i_addr = 32'h1EC0_0044;
        i_read = 1'b1;
        tick();
        total_cnt++;
        if ({bus.bmem_read, bus.bmem_addr} !== {1'b1, 32'h1EC0_0040})
            $display("FAIL icache_issue: got rd=%b addr=%h want rd=1 addr=1ec00040", bus.bmem_read, bus.bmem_addr);
        else pass_cnt++;
        serve_read(32'h1EC0_0040, ln, 1'b0, 32'h0);
        total_cnt++;
        if ({i_resp, d_resp} !== 2'b10) $display("FAIL icache_resp: got %b want 10", {i_resp, d_resp});
        else pass_cnt++;
        total_cnt++;
        if (i_rdata !== ln) $display("FAIL icache_rdata: got %h want %h", i_rdata, ln);
        else pass_cnt++;
        i_read = 1'b0;
        model_last_d = 1'b0;
        tick();
        total_cnt++;
        if ({i_resp, bus.bmem_read} !== 2'b00) $display("FAIL icache_pulse: got resp,rd=%b want 00", {i_resp, bus.bmem_read});
        else pass_cnt++;
    endtask

    task automatic test_dcache_write_stall();
        int exp_idx[6] = '{0, 1, 1, 1, 2, 3};
        logic [255:0] wl;
        logic [31:0] al;
        rand_line(wl);
        d_wdata = wl;
        d_addr  = $urandom;
        al      = d_addr & 32'hFFFF_FFE0;
        d_write = 1'b1;
        serve_write(1, 2);
        total_cnt++;
        if (first_wr_cyc !== 1) $display("FAIL wr_first_cycle: got %0d want 1", first_wr_cyc);
        else pass_cnt++;
        total_cnt++;
        if (resp_cyc !== 7) $display("FAIL wr_resp_cycle: got %0d want 7", resp_cyc);
        else pass_cnt++;
        total_cnt++;
        if ({i_resp, d_resp} !== 2'b01) $display("FAIL wr_resp: got %b want 01", {i_resp, d_resp});
        else pass_cnt++;
        total_cnt++;
        if (wr_trace.size() !== 6) $display("FAIL wr_cycles: got %0d want 6", wr_trace.size());
        else pass_cnt++;
        for (int j = 0; j < wr_trace.size() && j < 6; j++) begin
            total_cnt++;
            if ({wr_trace[j], waddr_trace[j]} !== {wl[64*exp_idx[j] +: 64], al})
                $display("FAIL wr_beat%0d: got data=%h addr=%h want data=%h addr=%h",
                         j, wr_trace[j], waddr_trace[j], wl[64*exp_idx[j] +: 64], al);
            else pass_cnt++;
        end
        d_write = 1'b0;
        model_last_d = 1'b1;
        tick();
        total_cnt++;
        if ({d_resp, bus.bmem_write} !== 2'b00) $display("FAIL wr_pulse: got resp,wr=%b want 00", {d_resp, bus.bmem_write});
        else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        logic [255:0] ln;
        logic [31:0]  ia, da, tag;
        bit first_d, cur_d;
        do_reset();
        dual_resp = 1'b0;
        for (int r = 0; r < 2; r++) begin
            ia = $urandom;
            da = ia ^ 32'h0001_0000;
            i_addr = ia; d_addr = da;
            i_read = 1'b1; d_read = 1'b1;
            first_d = !model_last_d;
            for (int s = 0; s < 2; s++) begin
                cur_d = (s == 0) ? first_d : !first_d;
                tag = (cur_d ? da : ia) & 32'hFFFF_FFE0;
                rand_line(ln);
                serve_read(tag, ln, 1'b0, 32'h0);
                total_cnt++;
                if (issue_addr !== tag) $display("FAIL sim_r%0d_s%0d_addr: got %h want %h", r, s, issue_addr, tag);
                else pass_cnt++;
                total_cnt++;
                if ({i_resp, d_resp} !== (cur_d ? 2'b01 : 2'b10))
                    $display("FAIL sim_r%0d_s%0d_resp: got %b want %b", r, s, {i_resp, d_resp}, cur_d ? 2'b01 : 2'b10);
                else pass_cnt++;
                total_cnt++;
                if ((cur_d ? d_rdata : i_rdata) !== ln)
                    $display("FAIL sim_r%0d_s%0d_rdata: got %h want %h", r, s, cur_d ? d_rdata : i_rdata, ln);
                else pass_cnt++;
                if (cur_d) d_read = 1'b0; else i_read = 1'b0;
                model_last_d = cur_d;
                tick();
            end
        end
        total_cnt++;
        if (dual_resp !== 1'b0) $display("FAIL sim_dual_resp: got %b want 0", dual_resp);
        else pass_cnt++;
    endtask

    task automatic test_stray_beats();
        logic [255:0] ln;
        bus.bmem_rvalid = 1'b1; bus.bmem_raddr = 32'h0000_2000; bus.bmem_rdata = {$urandom, $urandom};
        repeat (2) tick();
        bus.bmem_rvalid = 1'b0;
        d_addr = 32'h0000_2000;
        d_read = 1'b1;
        rand_line(ln);
        serve_read(32'h0000_2000, ln, 1'b1, 32'h0000_1000);
        total_cnt++;
        if ({i_resp, d_resp} !== 2'b01) $display("FAIL stray_resp: got %b want 01", {i_resp, d_resp});
        else pass_cnt++;
        total_cnt++;
        if (d_rdata !== ln) $display("FAIL stray_rdata: got %h want %h", d_rdata, ln);
        else pass_cnt++;
        d_read = 1'b0;
        model_last_d = 1'b1;
        tick();
        bus.bmem_rvalid = 1'b1; bus.bmem_raddr = 32'h0000_2000; bus.bmem_rdata = {$urandom, $urandom};
        repeat (2) tick();
        bus.bmem_rvalid = 1'b0;
        i_addr = 32'h0000_2000;
        i_read = 1'b1;
        rand_line(ln);
        serve_read(32'h0000_2000, ln, 1'b0, 32'h0);
        total_cnt++;
        if ({i_resp, i_rdata} !== {1'b1, ln}) $display("FAIL stray_idle_rdata: got resp=%b %h want 1 %h", i_resp, i_rdata, ln);
        else pass_cnt++;
        i_read = 1'b0;
        model_last_d = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_burst();
        logic [255:0] ln, ln2;
        logic [31:0]  a;
        bit resp_seen = 1'b0;
        int n = 0;
        a = $urandom & 32'hFFFF_FFE0;
        rand_line(ln);
        i_addr = a;
        i_read = 1'b1;
        while (bus.bmem_read !== 1'b1 && n < 20) begin tick(); n++; end
        bus.bmem_ready = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            bus.bmem_rvalid = 1'b1; bus.bmem_raddr = a; bus.bmem_rdata = ln[64*k +: 64];
            tick();
        end
        bus.bmem_rvalid = 1'b0;
        rst = 1'b1;
        i_read = 1'b0;
        tick();
        total_cnt++;
        if ({bus.bmem_read, bus.bmem_write, bus.bmem_addr, bus.bmem_wdata} !== 98'b0)
            $display("FAIL rstmid_bmem: got rd=%b wr=%b addr=%h want all 0", bus.bmem_read, bus.bmem_write, bus.bmem_addr);
        else pass_cnt++;
        total_cnt++;
        if ({i_resp, d_resp, i_rdata} !== 258'b0) $display("FAIL rstmid_cache: got resp=%b rdata=%h want 0", {i_resp, d_resp}, i_rdata);
        else pass_cnt++;
        rst = 1'b0;
        model_last_d = 1'b0;
        for (int k = 2; k < 4; k++) begin
            bus.bmem_rvalid = 1'b1; bus.bmem_raddr = a; bus.bmem_rdata = ln[64*k +: 64];
            tick();
            resp_seen |= (i_resp !== 1'b0) || (d_resp !== 1'b0);
        end
        bus.bmem_rvalid = 1'b0;
        tick();
        resp_seen |= (i_resp !== 1'b0) || (d_resp !== 1'b0);
        total_cnt++;
        if (resp_seen !== 1'b0) $display("FAIL rstmid_no_resp: got resp_seen=%b want 0", resp_seen);
        else pass_cnt++;
        rand_line(ln2);
        i_read = 1'b1;
        serve_read(a, ln2, 1'b0, 32'h0);
        total_cnt++;
        if ({i_resp, i_rdata} !== {1'b1, ln2}) $display("FAIL rstmid_new_read: got resp=%b %h want 1 %h", i_resp, i_rdata, ln2);
        else pass_cnt++;
        i_read = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [255:0] ln, wl;
        d_addr = $urandom;
        d_read = 1'b1;
        rand_line(ln);
        serve_read(d_addr & 32'hFFFF_FFE0, ln, 1'b0, 32'h0);
        total_cnt++;
        if ({d_resp, d_rdata} !== {1'b1, ln}) $display("FAIL b2b_read: got resp=%b %h want 1 %h", d_resp, d_rdata, ln);
        else pass_cnt++;
        rand_line(wl);
        d_read = 1'b0; d_write = 1'b1; d_wdata = wl;
        model_last_d = 1'b1;
        serve_write(-1, 0);
        total_cnt++;
        if ({first_wr_cyc, resp_cyc} !== {32'd2, 32'd6})
            $display("FAIL b2b_timing: got first_wr=%0d resp=%0d want 2 6", first_wr_cyc, resp_cyc);
        else pass_cnt++;
        total_cnt++;
        if (wr_trace.size() !== 4) $display("FAIL b2b_wr_cycles: got %0d want 4", wr_trace.size());
        else pass_cnt++;
        for (int j = 0; j < wr_trace.size() && j < 4; j++) begin
            total_cnt++;
            if (wr_trace[j] !== wl[64*j +: 64]) $display("FAIL b2b_beat%0d: got %h want %h", j, wr_trace[j], wl[64*j +: 64]);
            else pass_cnt++;
        end
        d_write = 1'b0;
        tick();
    endtask

    task automatic test_random_mix();
        logic [255:0] ln, wl;
        logic [31:0]  ia, da, tag;
        logic [63:0]  exp_q[$];
        int p, sb, sl;
        bit dwr, both, win_d, cur_d;
        dual_resp = 1'b0;
        for (int it = 0; it < 12; it++) begin
            p   = $urandom_range(0, 2);
            dwr = 1'($urandom_range(0, 1));
            ia  = $urandom;
            da  = ia ^ 32'h0040_0000;
            rand_line(wl);
            i_addr = ia; d_addr = da; d_wdata = wl;
            i_read  = (p != 1);
            d_read  = (p != 0) && !dwr;
            d_write = (p != 0) && dwr;
            both  = (p == 2);
            win_d = both ? !model_last_d : (p == 1);
            for (int s = 0; s < (both ? 2 : 1); s++) begin
                cur_d = (s == 0) ? win_d : !win_d;
                if (cur_d && dwr) begin
                    sb = $urandom_range(0, 3);
                    sl = $urandom_range(0, 2);
                    serve_write(sb, sl);
                    exp_q.delete();
                    for (int b = 0; b < 4; b++)
                        repeat ((b == sb) ? sl + 1 : 1) exp_q.push_back(wl[64*b +: 64]);
                    total_cnt++;
                    if ({i_resp, d_resp} !== 2'b01) $display("FAIL rnd%0d_wr_resp: got %b want 01", it, {i_resp, d_resp});
                    else pass_cnt++;
                    total_cnt++;
                    if (wr_trace.size() !== exp_q.size())
                        $display("FAIL rnd%0d_wr_cycles: got %0d want %0d", it, wr_trace.size(), exp_q.size());
                    else pass_cnt++;
                    for (int j = 0; j < wr_trace.size() && j < exp_q.size(); j++) begin
                        total_cnt++;
                        if (wr_trace[j] !== exp_q[j]) $display("FAIL rnd%0d_wr_beat%0d: got %h want %h", it, j, wr_trace[j], exp_q[j]);
                        else pass_cnt++;
                    end
                    d_write = 1'b0;
                end else begin
                    tag = (cur_d ? da : ia) & 32'hFFFF_FFE0;
                    rand_line(ln);
                    serve_read(tag, ln, 1'b0, 32'h0);
                    total_cnt++;
                    if (issue_addr !== tag) $display("FAIL rnd%0d_rd_addr: got %h want %h", it, issue_addr, tag);
                    else pass_cnt++;
                    total_cnt++;
                    if ({i_resp, d_resp, (cur_d ? d_rdata : i_rdata)} !== {!cur_d, cur_d, ln})
                        $display("FAIL rnd%0d_rd: got resp=%b %h want resp=%b %h", it, {i_resp, d_resp},
                                 cur_d ? d_rdata : i_rdata, {!cur_d, cur_d}, ln);
                    else pass_cnt++;
                    if (cur_d) d_read = 1'b0; else i_read = 1'b0;
                end
                model_last_d = cur_d;
                tick();
            end
        end
        total_cnt++;
        if (dual_resp !== 1'b0) $display("FAIL rnd_dual_resp: got %b want 0", dual_resp);
        else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        i_addr = 32'h0; d_addr = 32'h0; d_wdata = '0;
        bus.bmem_ready = 1'b1; bus.bmem_rvalid = 1'b0;
        bus.bmem_raddr = 32'h0; bus.bmem_rdata = 64'h0;
        model_last_d = 1'b0;
        dual_resp = 1'b0;
        tick();
        test_reset();
        test_icache_read();
        test_dcache_write_stall();
        test_simultaneous();
        test_stray_beats();
        test_reset_mid_burst();
        test_back_to_back();
        test_random_mix();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
